vm_sched: RTL and testbench

Time-slice scheduler that sequences guest execution on the virtual machine control structure. It picks ready guests round-robin, issues the single-cycle `vm_on`/`vm_off` commands with the guest VMID, and enforces a per-entry quantum. It reports every exit with a cause and waits for the host handler before re-entering on a guest trap. It sits between the hypervisor control registers and the VMCS.

---
 rtl/vm_pkg.sv | 27 ++
 rtl/rr_picker.sv | 28 ++
 rtl/vm_sched.sv | 149 ++++++++++++++
 tb/tb_vm_sched.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared types for the guest time-slice scheduler: exit causes, FSM states, VMID width.
package vm_pkg;

    localparam int unsigned VMID_W = 8;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_TRAP    = 2'd1,
        CAUSE_PREEMPT = 2'd2,
        CAUSE_DISABLE = 2'd3
    } exit_cause_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_ENTER  = 3'd2,
        ST_RUN    = 3'd3,
        ST_EXIT   = 3'd4,
        ST_HOST   = 3'd5
    } vm_sched_state_e;

    // A zero quantum still grants one RUN cycle.
    function automatic logic [31:0] quantum_load(input logic [31:0] q);
        return (q == 32'd0) ? 32'd1 : q;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin find-first: first set request strictly after last_i, wrapping.
module rr_picker #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] grant_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] idx;

    // Walk from the farthest candidate back to the nearest so the nearest hit wins.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int unsigned i = N; i >= 1; i--) begin
            idx = IDX_W'((32'(last_i) + i) % N);
            if (req_i[idx]) begin
                grant_o = idx;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vm_sched.sv
// Round-robin guest time-slice scheduler driving vm_on/vm_off commands to the VMCS,
// with per-entry quantum enforcement, exit cause reporting and host trap handshake.
module vm_sched
    import vm_pkg::*;
#(
    parameter int unsigned NUM_VMS   = 4,
    parameter int unsigned QUANTUM_W = 16,
    parameter int unsigned CNT_W     = 16,
    localparam int unsigned SLOT_W   = $clog2(NUM_VMS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sched_en_i,
    input  logic [NUM_VMS-1:0]   vm_ready_i,
    input  logic [QUANTUM_W-1:0] quantum_i,
    input  logic                 exit_req_i,
    input  logic                 host_done_i,
    output logic                 vm_on_o,
    output logic                 vm_off_o,
    output logic [VMID_W-1:0]    vmid_o,
    output logic [SLOT_W-1:0]    cur_slot_o,
    output logic                 running_o,
    output logic                 exit_valid_o,
    output logic [1:0]           exit_cause_o,
    output logic [CNT_W-1:0]     entry_cnt_o
);

    vm_sched_state_e      state_q, state_d;
    logic [QUANTUM_W-1:0] qcnt_q, qcnt_d;
    logic [SLOT_W-1:0]    last_q, last_d;
    logic [SLOT_W-1:0]    slot_q, slot_d;
    logic [VMID_W-1:0]    vmid_q, vmid_d;
    logic [CNT_W-1:0]     entry_q, entry_d;
    exit_cause_e          cause_q, cause_d;

    logic [SLOT_W-1:0]    pick_slot;
    logic                 pick_valid;

    rr_picker #(
        .N     (NUM_VMS),
        .IDX_W (SLOT_W)
    ) u_picker (
        .req_i   (vm_ready_i),
        .last_i  (last_q),
        .grant_o (pick_slot),
        .valid_o (pick_valid)
    );

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            qcnt_q  <= '0;
            last_q  <= SLOT_W'(NUM_VMS - 1);
            slot_q  <= '0;
            vmid_q  <= '0;
            entry_q <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            last_q  <= last_d;
            slot_q  <= slot_d;
            vmid_q  <= vmid_d;
            entry_q <= entry_d;
            cause_q <= cause_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        last_d  = last_q;
        slot_d  = slot_q;
        vmid_d  = vmid_q;
        entry_d = entry_q;
        cause_d = cause_q;

        case (state_q)
            ST_IDLE: begin
                if (sched_en_i && (|vm_ready_i)) begin
                    state_d = ST_SELECT;
                end
            end

            ST_SELECT: begin
                if (sched_en_i && pick_valid) begin
                    slot_d  = pick_slot;
                    last_d  = pick_slot;
                    vmid_d  = VMID_W'(pick_slot) + VMID_W'(1);
                    state_d = ST_ENTER;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ENTER: begin
                qcnt_d  = QUANTUM_W'(quantum_load(32'(quantum_i)));
                entry_d = entry_q + CNT_W'(1);
                state_d = ST_RUN;
            end

            // Trap outranks disable, which outranks quantum expiry.
            ST_RUN: begin
                qcnt_d = qcnt_q - QUANTUM_W'(1);
                if (exit_req_i) begin
                    cause_d = CAUSE_TRAP;
                    state_d = ST_EXIT;
                end else if (!sched_en_i) begin
                    cause_d = CAUSE_DISABLE;
                    state_d = ST_EXIT;
                end else if (qcnt_q == QUANTUM_W'(1)) begin
                    cause_d = CAUSE_PREEMPT;
                    state_d = ST_EXIT;
                end
            end

            ST_EXIT: begin
                case (cause_q)
                    CAUSE_TRAP:    state_d = ST_HOST;
                    CAUSE_DISABLE: state_d = ST_IDLE;
                    default:       state_d = ST_SELECT;
                endcase
            end

            ST_HOST: begin
                if (host_done_i) begin
                    state_d = sched_en_i ? ST_SELECT : ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        vm_on_o      = (state_q == ST_ENTER);
        vm_off_o     = (state_q == ST_EXIT);
        running_o    = (state_q == ST_RUN);
        exit_valid_o = (state_q == ST_EXIT);
        exit_cause_o = cause_q;
        vmid_o       = vmid_q;
        cur_slot_o   = slot_q;
        entry_cnt_o  = entry_q;
    end

endmodule

// File: tb/tb_vm_sched.sv
// Scoreboard bench for vm_sched: stimulus queues expected vm_on/vm_off events, a monitor checks them.
module tb_vm_sched;

    logic        clk;
    logic        rst;
    logic        sched_en;
    logic [3:0]  vm_ready;
    logic [15:0] quantum;
    logic        exit_req;
    logic        host_done;
    logic        vm_on;
    logic        vm_off;
    logic [7:0]  vmid;
    logic [1:0]  cur_slot;
    logic        running;
    logic        exit_valid;
    logic [1:0]  exit_cause;
    logic [15:0] entry_cnt;

    vm_sched #(
        .NUM_VMS   (4),
        .QUANTUM_W (16),
        .CNT_W     (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sched_en_i   (sched_en),
        .vm_ready_i   (vm_ready),
        .quantum_i    (quantum),
        .exit_req_i   (exit_req),
        .host_done_i  (host_done),
        .vm_on_o      (vm_on),
        .vm_off_o     (vm_off),
        .vmid_o       (vmid),
        .cur_slot_o   (cur_slot),
        .running_o    (running),
        .exit_valid_o (exit_valid),
        .exit_cause_o (exit_cause),
        .entry_cnt_o  (entry_cnt)
    );

    typedef struct {
        bit          is_on;
        int unsigned cyc;
        logic [7:0]  vmid;
        logic [1:0]  cause;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_on(input int unsigned c, input logic [7:0] v);
        exp_t e;
        e.is_on = 1'b1; e.cyc = c; e.vmid = v; e.cause = 2'd0;
        exp_q.push_back(e);
    endtask

    task automatic push_off(input int unsigned c, input logic [7:0] v, input logic [1:0] cause);
        exp_t e;
        e.is_on = 1'b0; e.cyc = c; e.vmid = v; e.cause = cause;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every command pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (vm_on || vm_off) begin
            check("on_off_exclusive", 32'(vm_on & vm_off), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_cmd", 32'({vm_on, vm_off}), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("cmd_kind_on", 32'(vm_on), 32'(e.is_on));
                check("cmd_cycle", cyc, e.cyc);
                check("cmd_vmid", 32'(vmid), 32'(e.vmid));
                check("cmd_cur_slot", 32'(cur_slot), 32'(e.vmid - 8'd1));
                if (!e.is_on) begin
                    check("exit_valid", 32'(exit_valid), 32'd1);
                    check("exit_cause", 32'(exit_cause), 32'(e.cause));
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_vm_on"}, 32'(vm_on), 32'd0);
        check({tag, "_vm_off"}, 32'(vm_off), 32'd0);
        check({tag, "_vmid"}, 32'(vmid), 32'd0);
        check({tag, "_cur_slot"}, 32'(cur_slot), 32'd0);
        check({tag, "_running"}, 32'(running), 32'd0);
        check({tag, "_exit_valid"}, 32'(exit_valid), 32'd0);
        check({tag, "_exit_cause"}, 32'(exit_cause), 32'd0);
        check({tag, "_entry_cnt"}, 32'(entry_cnt), 32'd0);
    endtask

    int unsigned c0, c1, c2;

    initial begin
        rst = 1'b1; sched_en = 1'b0; vm_ready = 4'b0000; quantum = 16'd5;
        exit_req = 1'b0; host_done = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Round-robin rotation, quantum 5: on every 8 cycles, off 6 after each on.
        @(negedge clk);
        c0 = cyc;
        vm_ready = 4'b1111; sched_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            push_on(c0 + 2 + 8 * k, 8'((k % 4) + 1));
            push_off(c0 + 8 + 8 * k, 8'((k % 4) + 1), 2'd2);
        end
        push_on(c0 + 42, 8'd2);
        push_off(c0 + 45, 8'd2, 2'd3);
        wait_until(c0 + 44);
        sched_en = 1'b0;
        wait_until(c0 + 46);
        check("disable_running", 32'(running), 32'd0);
        check("disable_entry_cnt", 32'(entry_cnt), 32'd6);

        // Enabled with nothing ready: must stay idle with no pulses.
        vm_ready = 4'b0000; sched_en = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("no_ready_running", 32'(running), 32'd0);
        end

        // Trap, host wait, zero quantum, trap/expiry collision.
        @(negedge clk);
        c1 = cyc;
        vm_ready = 4'b1111; quantum = 16'd5;
        push_on(c1 + 2, 8'd3);
        push_off(c1 + 5, 8'd3, 2'd1);
        push_on(c1 + 12, 8'd4);
        push_off(c1 + 18, 8'd4, 2'd2);
        push_on(c1 + 20, 8'd1);
        push_off(c1 + 22, 8'd1, 2'd2);
        push_on(c1 + 24, 8'd2);
        push_off(c1 + 26, 8'd2, 2'd2);
        push_on(c1 + 28, 8'd3);
        push_off(c1 + 32, 8'd3, 2'd1);
        wait_until(c1 + 4);
        exit_req = 1'b1;
        wait_until(c1 + 5);
        exit_req = 1'b0;
        wait_until(c1 + 8);
        check("host_wait_running", 32'(running), 32'd0);
        wait_until(c1 + 10);
        host_done = 1'b1;
        wait_until(c1 + 11);
        host_done = 1'b0;
        wait_until(c1 + 13);
        quantum = 16'd0;
        wait_until(c1 + 21);
        check("zero_q_run_cycle", 32'(running), 32'd1);
        wait_until(c1 + 22);
        check("zero_q_exit_cycle", 32'(running), 32'd0);
        wait_until(c1 + 25);
        quantum = 16'd3;
        wait_until(c1 + 31);
        exit_req = 1'b1;
        wait_until(c1 + 32);
        exit_req = 1'b0;
        wait_until(c1 + 36);
        sched_en = 1'b0; host_done = 1'b1;
        wait_until(c1 + 37);
        host_done = 1'b0;
        check("collision_entry_cnt", 32'(entry_cnt), 32'd11);
        check("collision_cause_hold", 32'(exit_cause), 32'd1);

        // Reset mid-RUN suppresses the exit; sparse ready picks slot 1 first.
        wait_until(c1 + 40);
        c2 = cyc;
        sched_en = 1'b1; quantum = 16'd5; vm_ready = 4'b1111;
        push_on(c2 + 2, 8'd4);
        push_on(c2 + 8, 8'd2);
        push_off(c2 + 14, 8'd2, 2'd2);
        push_on(c2 + 16, 8'd4);
        push_off(c2 + 18, 8'd4, 2'd3);
        wait_until(c2 + 3);
        check("pre_reset_running", 32'(running), 32'd1);
        wait_until(c2 + 4);
        rst = 1'b1;
        wait_until(c2 + 5);
        check_all_zero("midrun_reset");
        vm_ready = 4'b1010;
        wait_until(c2 + 6);
        rst = 1'b0;
        wait_until(c2 + 9);
        check("post_reset_entry_cnt", 32'(entry_cnt), 32'd1);
        check("post_reset_running", 32'(running), 32'd1);
        wait_until(c2 + 17);
        sched_en = 1'b0;
        wait_until(c2 + 22);
        check("events_outstanding", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
